// File: rtl/apb_i2c_fifo_if.sv
// apb_i2c_fifo_if -- APB3 slave bus bundle for apb_i2c_fifo.
//
// Signals: PADDR, PWDATA, PWRITE, PSEL, PENABLE (master -> slave);
//          PRDATA, PREADY, PSLVERR (slave -> master).
// Modports: master (bus driver / testbench), slave (apb_i2c_fifo).
//
// Handshake: a transfer is a setup cycle (PSEL=1, PENABLE=0) followed by an
// access cycle (PSEL=1, PENABLE=1). The slave commits writes and read side
// effects on the access cycle where PREADY=1; this slave never inserts wait
// states (PREADY=1) and never signals an error (PSLVERR=0).
interface apb_i2c_fifo_if #(
    parameter int ADDR_W = 12
) ();
    logic [ADDR_W-1:0] PADDR;
    logic [31:0]       PWDATA;
    logic              PWRITE;
    logic              PSEL;
    logic              PENABLE;
    logic [31:0]       PRDATA;
    logic              PREADY;
    logic              PSLVERR;

    modport master (
        output PADDR, PWDATA, PWRITE, PSEL, PENABLE,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PADDR, PWDATA, PWRITE, PSEL, PENABLE,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/apb_i2c_fifo.sv
// apb_i2c_fifo -- APB-programmed command/response FIFOs in front of an I2C
// byte controller.
//
// Ports:
//   HCLK, HRESETn          clock, asynchronous active-low reset
//   apb                    APB slave bundle (apb_i2c_fifo_if.slave)
//   start_o..ack_in_o,din_o command to the byte controller (valid in WAIT)
//   cmd_ack_i, ack_out_i, i2c_al_i, i2c_busy_i, dout_i  byte controller status
//   interrupt_o            registered level interrupt
//   core_en_o, clk_cnt_o   CTRL.EN and PRESCALE to the byte controller
//   fsm_state_o            debug view of the command FSM state
//
// Build option: define APB_I2C_FIFO_THRESH_EN to make TX_TL/RX_TL writable
// and drive the level-sensitive TX_THR/RX_THR interrupt bits.
`default_nettype none

module apb_i2c_fifo #(
    parameter int APB_ADDR_WIDTH = 12,
    parameter int FIFO_DEPTH     = 8
) (
    input  wire logic        HCLK,
    input  wire logic        HRESETn,
    apb_i2c_fifo_if.slave    apb,
    output logic             start_o,
    output logic             stop_o,
    output logic             read_o,
    output logic             write_o,
    output logic             ack_in_o,
    output logic [7:0]       din_o,
    input  wire logic        cmd_ack_i,
    input  wire logic        ack_out_i,
    input  wire logic        i2c_al_i,
    input  wire logic        i2c_busy_i,
    input  wire logic [7:0]  dout_i,
    output logic             interrupt_o,
    output logic             core_en_o,
    output logic [15:0]      clk_cnt_o,
    output logic [1:0]       fsm_state_o
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [APB_ADDR_WIDTH-1:0] A_PRE  = APB_ADDR_WIDTH'(8'h00);
    localparam logic [APB_ADDR_WIDTH-1:0] A_CTRL = APB_ADDR_WIDTH'(8'h04);
    localparam logic [APB_ADDR_WIDTH-1:0] A_STAT = APB_ADDR_WIDTH'(8'h08);
    localparam logic [APB_ADDR_WIDTH-1:0] A_TXD  = APB_ADDR_WIDTH'(8'h0C);
    localparam logic [APB_ADDR_WIDTH-1:0] A_RXD  = APB_ADDR_WIDTH'(8'h10);
    localparam logic [APB_ADDR_WIDTH-1:0] A_TXTL = APB_ADDR_WIDTH'(8'h14);
    localparam logic [APB_ADDR_WIDTH-1:0] A_RXTL = APB_ADDR_WIDTH'(8'h18);
    localparam logic [APB_ADDR_WIDTH-1:0] A_ISTA = APB_ADDR_WIDTH'(8'h1C);
    localparam logic [APB_ADDR_WIDTH-1:0] A_MASK = APB_ADDR_WIDTH'(8'h20);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_HALT} state_t;
    state_t state_q, state_d;

    logic        wr, rd;
    logic [15:0] prescale_q, prescale_d;
    logic        en_q, en_d, ien_q, ien_d;
    logic [6:0]  mask_q, mask_d;
    logic [4:0]  stat_q, stat_d;     // W1C bits: RX_OVF TX_OVF AL NACK DONE
    logic        irq_q;
    logic [11:0] cmd_q;
    logic        tx_thr, rx_thr;
    logic        nack_set, al_set, done_set;

    logic [11:0] tx_mem [FIFO_DEPTH];
    logic [PW-1:0] tx_wp_q, tx_rp_q;
    logic [CW-1:0] tx_cnt_q;
    logic        tx_full, tx_empty, tx_push_req, tx_push, tx_pop, tx_flush;
    logic [7:0]  rx_mem [FIFO_DEPTH];
    logic [PW-1:0] rx_wp_q, rx_rp_q;
    logic [CW-1:0] rx_cnt_q;
    logic        rx_full, rx_empty, rx_push_req, rx_push, rx_pop, rx_flush;
    logic [7:0]  tx_lvl, rx_lvl;
    logic        unused_bits;

    assign wr = apb.PSEL & apb.PENABLE & apb.PWRITE;
    assign rd = apb.PSEL & apb.PENABLE & ~apb.PWRITE;
    assign apb.PREADY  = 1'b1;
    assign apb.PSLVERR = 1'b0;
    assign unused_bits = ^apb.PWDATA[31:16];

    // ---------------- TX FIFO ----------------
    assign tx_full     = tx_cnt_q == CW'(FIFO_DEPTH);
    assign tx_empty    = tx_cnt_q == '0;
    assign tx_lvl      = 8'(tx_cnt_q);
    assign tx_pop      = (state_q == S_ISSUE) & ~tx_empty;
    assign tx_push_req = wr & (apb.PADDR == A_TXD);
    // A pop in the same cycle frees the slot, so a push at full still lands.
    assign tx_push     = tx_push_req & (~tx_full | tx_pop);
    // Flushing never touches cmd_q, so an in-flight command keeps running.
    assign tx_flush    = (wr & (apb.PADDR == A_CTRL) & apb.PWDATA[1]) | nack_set | al_set;

    always_ff @(posedge HCLK) begin
        if (tx_push) tx_mem[tx_wp_q] <= apb.PWDATA[11:0];
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            tx_wp_q  <= '0;
            tx_rp_q  <= '0;
            tx_cnt_q <= '0;
        end else if (tx_flush) begin
            tx_wp_q  <= '0;
            tx_rp_q  <= '0;
            tx_cnt_q <= '0;
        end else begin
            if (tx_push) tx_wp_q <= tx_wp_q + PW'(1);
            if (tx_pop)  tx_rp_q <= tx_rp_q + PW'(1);
            tx_cnt_q <= tx_cnt_q + CW'(tx_push) - CW'(tx_pop);
        end
    end

    // ---------------- RX FIFO ----------------
    assign rx_full     = rx_cnt_q == CW'(FIFO_DEPTH);
    assign rx_empty    = rx_cnt_q == '0;
    assign rx_lvl      = 8'(rx_cnt_q);
    assign rx_pop      = rd & (apb.PADDR == A_RXD) & ~rx_empty;
    assign rx_push_req = (state_q == S_WAIT) & cmd_ack_i & ~i2c_al_i & cmd_q[10];
    assign rx_push     = rx_push_req & (~rx_full | rx_pop);
    assign rx_flush    = wr & (apb.PADDR == A_CTRL) & apb.PWDATA[2];

    always_ff @(posedge HCLK) begin
        if (rx_push) rx_mem[rx_wp_q] <= dout_i;
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            rx_wp_q  <= '0;
            rx_rp_q  <= '0;
            rx_cnt_q <= '0;
        end else if (rx_flush) begin
            rx_wp_q  <= '0;
            rx_rp_q  <= '0;
            rx_cnt_q <= '0;
        end else begin
            if (rx_push) rx_wp_q <= rx_wp_q + PW'(1);
            if (rx_pop)  rx_rp_q <= rx_rp_q + PW'(1);
            rx_cnt_q <= rx_cnt_q + CW'(rx_push) - CW'(rx_pop);
        end
    end

    // ---------------- command FSM ----------------
    always_comb begin
        state_d  = state_q;
        nack_set = 1'b0;
        al_set   = 1'b0;
        done_set = 1'b0;
        unique case (state_q)
            S_IDLE:  if (en_q && !tx_empty) state_d = S_ISSUE;
            // A flush can empty the queue between IDLE and ISSUE; fall back.
            S_ISSUE: state_d = tx_empty ? S_IDLE : S_WAIT;
            S_WAIT: begin
                if (i2c_al_i) begin
                    al_set  = 1'b1;
                    state_d = S_HALT;
                end else if (cmd_ack_i) begin
                    if (!cmd_q[10] && ack_out_i) begin
                        nack_set = 1'b1;
                        state_d  = S_HALT;
                    end else begin
                        done_set = tx_empty;
                        state_d  = S_IDLE;
                    end
                end
            end
            S_HALT:  if (!stat_q[1] && !stat_q[2]) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q <= S_IDLE;
            cmd_q   <= '0;
        end else begin
            state_q <= state_d;
            if (tx_pop) cmd_q <= tx_mem[tx_rp_q];
        end
    end

    // Command lines are live only in WAIT, so they drop with the state.
    assign start_o     = (state_q == S_WAIT) & cmd_q[8];
    assign stop_o      = (state_q == S_WAIT) & cmd_q[9];
    assign read_o      = (state_q == S_WAIT) & cmd_q[10];
    assign write_o     = (state_q == S_WAIT) & ~cmd_q[10];
    assign ack_in_o    = (state_q == S_WAIT) & cmd_q[11];
    assign din_o       = (state_q == S_WAIT) ? cmd_q[7:0] : 8'h00;
    assign fsm_state_o = state_q;

    // ---------------- thresholds ----------------
`ifdef APB_I2C_FIFO_THRESH_EN
    logic [7:0] tx_tl_q, tx_tl_d, rx_tl_q, rx_tl_d;
    assign tx_thr = tx_lvl <= tx_tl_q;
    assign rx_thr = rx_lvl > rx_tl_q;
    always_comb begin
        tx_tl_d = tx_tl_q;
        rx_tl_d = rx_tl_q;
        if (wr && apb.PADDR == A_TXTL) tx_tl_d = apb.PWDATA[7:0];
        if (wr && apb.PADDR == A_RXTL) rx_tl_d = apb.PWDATA[7:0];
    end
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            tx_tl_q <= '0;
            rx_tl_q <= '0;
        end else begin
            tx_tl_q <= tx_tl_d;
            rx_tl_q <= rx_tl_d;
        end
    end
`else
    assign tx_thr = 1'b0;
    assign rx_thr = 1'b0;
`endif

    // ---------------- registers ----------------
    always_comb begin
        prescale_d = prescale_q;
        en_d       = en_q;
        ien_d      = ien_q;
        mask_d     = mask_q;
        stat_d     = stat_q;
        if (wr && apb.PADDR == A_PRE)  prescale_d = apb.PWDATA[15:0];
        if (wr && apb.PADDR == A_CTRL) begin
            en_d  = apb.PWDATA[7];
            ien_d = apb.PWDATA[6];
        end
        if (wr && apb.PADDR == A_MASK) mask_d = apb.PWDATA[6:0];
        if (wr && apb.PADDR == A_ISTA) stat_d = stat_d & ~apb.PWDATA[4:0];
        // New events win over a simultaneous clear.
        stat_d = stat_d | {rx_push_req & ~rx_push, tx_push_req & ~tx_push,
                           al_set, nack_set, done_set};
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            prescale_q <= '0;
            en_q       <= 1'b0;
            ien_q      <= 1'b0;
            mask_q     <= '0;
            stat_q     <= '0;
            irq_q      <= 1'b0;
        end else begin
            prescale_q <= prescale_d;
            en_q       <= en_d;
            ien_q      <= ien_d;
            mask_q     <= mask_d;
            stat_q     <= stat_d;
            irq_q      <= ien_q & |({rx_thr, tx_thr, stat_q} & mask_q);
        end
    end

    assign interrupt_o = irq_q;
    assign core_en_o   = en_q;
    assign clk_cnt_o   = prescale_q;

    // ---------------- read mux ----------------
    always_comb begin
        apb.PRDATA = 32'h0;
        case (apb.PADDR)
            A_PRE:  apb.PRDATA = {16'h0, prescale_q};
            A_CTRL: apb.PRDATA = {24'h0, en_q, ien_q, 6'h0};
            A_STAT: apb.PRDATA = {8'h0, rx_lvl, tx_lvl, 1'b0, state_q == S_HALT,
                                  i2c_busy_i, rx_empty, rx_full, tx_empty, tx_full,
                                  state_q != S_IDLE};
            A_RXD:  apb.PRDATA = rx_empty ? 32'h0 : {24'h0, rx_mem[rx_rp_q]};
`ifdef APB_I2C_FIFO_THRESH_EN
            A_TXTL: apb.PRDATA = {24'h0, tx_tl_q};
            A_RXTL: apb.PRDATA = {24'h0, rx_tl_q};
`endif
            A_ISTA: apb.PRDATA = {25'h0, rx_thr, tx_thr, stat_q};
            A_MASK: apb.PRDATA = {25'h0, mask_q};
            default: apb.PRDATA = 32'h0;
        endcase
    end
endmodule

`default_nettype wire

// File: doc/apb_i2c_fifo.md
APB_I2C_FIFO -- requirements
Module: apb_i2c_fifo

Interface
REQ-001 SHALL have parameter APB_ADDR_WIDTH, default 12, APB address width.
REQ-002 SHALL have parameter FIFO_DEPTH, default 8, entries per TX and RX FIFO; power of 2, range 2..128.
REQ-003 SHALL have these ports: HCLK in 1, clock; HRESETn in 1, asynchronous active-low reset.
REQ-004 SHALL have APB ports: PADDR in APB_ADDR_WIDTH; PWDATA in 32; PWRITE, PSEL, PENABLE in 1; PRDATA out 32; PREADY out 1 (tied 1); PSLVERR out 1 (tied 0).
REQ-005 SHALL have byte-controller ports: start_o, stop_o, read_o, write_o, ack_in_o out 1; din_o out 8; cmd_ack_i, ack_out_i, i2c_al_i, i2c_busy_i in 1; dout_i in 8.
REQ-006 SHALL have the following outputs: interrupt_o out 1, level interrupt; core_en_o out 1 (CTRL.EN); clk_cnt_o out 16 (PRESCALE).

Function
REQ-007 SHALL commit writes and RX pops only when PSEL&PENABLE is asserted; PRDATA is combinational; unmapped addresses read 0 and ignore writes.
REQ-008 SHALL implement this map:
- 0x00 PRESCALE[15:0].
- 0x04 CTRL: [7] EN, [6] IEN, [1] TXFLUSH, [2] RXFLUSH; flush bits are self-clearing and read 0.
- 0x08 STATUS (RO): [0] fsm!=IDLE, [1] txfull, [2] txempty, [3] rxfull, [4] rxempty, [5] i2c_busy_i, [6] halted, [15:8] txlevel, [23:16] rxlevel.
- 0x0C TXDATA (WO): push {PWDATA[11:0]}: [7:0] data, [8] START, [9] STOP, [10] READ (0=write), [11] ACK for reads.
- 0x10 RXDATA (RO): returns head byte and pops.
- 0x14 TX_TL, 0x18 RX_TL.
- 0x1C INTR_STAT: W1C.
- 0x20 INTR_MASK[6:0].
REQ-009 SHALL use INTR_STAT bits: 0 DONE, 1 NACK, 2 AL, 3 TX_OVF, 4 RX_OVF, 5 TX_THR, 6 RX_THR.
REQ-010 SHALL drop a TXDATA push when TX is full and set TX_OVF; simultaneous FSM pop and push at full SHALL both succeed.
REQ-011 SHALL return 0 on an RXDATA read when RX is empty, with no pointer change; simultaneous APB pop and FSM push at full SHALL both succeed.
REQ-012 SHALL implement FSM states IDLE, ISSUE, WAIT, HALT.
REQ-013 IDLE->ISSUE SHALL occur when EN=1, TX not empty and not HALT; ISSUE pops the head into a command register, then goes to WAIT next cycle.
REQ-014 In WAIT, the FSM SHALL hold start_o/stop_o/read_o/write_o/ack_in_o/din_o from the command register until cmd_ack_i, then deassert them in the same cycle the state leaves WAIT.
REQ-015 On cmd_ack_i for a read, dout_i SHALL be pushed to RX; if RX is full the byte is dropped and RX_OVF is set.
REQ-016 On cmd_ack_i for a write with ack_out_i=1, the block SHALL set NACK, flush TX and go to HALT; otherwise the FSM returns to IDLE.
REQ-017 i2c_al_i=1 in WAIT SHALL set AL, flush TX, clear command outputs and go to HALT.
REQ-018 HALT->IDLE SHALL occur only when NACK and AL are both 0 (after W1C).
REQ-019 DONE SHALL be set on the WAIT->IDLE exit when TX is empty.
REQ-020 Clearing EN during ISSUE/WAIT SHALL let the current command complete; no new issue follows; FIFO contents are kept.
REQ-021 TXFLUSH during WAIT SHALL empty the queue only; the in-flight command continues.
REQ-022 interrupt_o SHALL be registered, equal to IEN & |(INTR_STAT & INTR_MASK), with 1-cycle latency.

Reset
REQ-023 HRESETn low SHALL asynchronously force: FSM IDLE, FIFOs empty, all registers 0, all command outputs 0, interrupt_o 0, core_en_o 0, clk_cnt_o 0.
REQ-024 Reset mid-WAIT SHALL abandon the command with no DONE/NACK/AL set.

Configuration
REQ-025 With macro APB_I2C_FIFO_THRESH_EN defined, TX_TL/RX_TL SHALL be RW, and the threshold bits are level-sensitive, not W1C:
- TX_THR = txlevel <= TX_TL.
- RX_THR = rxlevel > RX_TL.
REQ-026 Without APB_I2C_FIFO_THRESH_EN, TX_TL/RX_TL SHALL read 0, ignore writes, and INTR_STAT[6:5] SHALL be 0.

Verification
REQ-027 Push 0x1A0 (START|write 0xA0), then 0x255 (STOP|write 0x55); ack each cmd_ack_i with ack_out_i=0 -> two commands issued in order, DONE=1, STATUS.txempty=1.
REQ-028 Push 0xC00 (READ|ACK); cmd_ack_i with dout_i=0x3C -> RXDATA reads 0x3C, then reads 0 with rxempty=1.
REQ-029 Write with ack_out_i=1 and 3 queued entries -> NACK=1, txlevel=0, HALT; W1C 0x2 -> IDLE; with IEN=1 and MASK=0x2, interrupt_o rises 1 cycle after NACK.
REQ-030 Push FIFO_DEPTH+1 entries with EN=0 -> txlevel=FIFO_DEPTH, TX_OVF=1.
REQ-031 i2c_al_i pulse in WAIT -> AL=1, command outputs 0 the next cycle, HALT.
REQ-032 With APB_I2C_FIFO_THRESH_EN defined: RX_TL=1, two reads completed -> RX_THR=1; pop one -> RX_THR=0.
